inst_decode: RTL

//   RV32I decode stage directly downstream of instruction fetch. Consumes the IF/ID word {pc, instr}.

---
 rtl/inst_decode_if.sv | 39 +++
 rtl/inst_decode.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_decode_if.sv
// IF/ID word in, WB write port, EX hazard info and flush in; ID/EX pipeline register and stall out.
// master = fetch/pipeline side, slave = the decode stage.
interface inst_decode_if #(
    parameter int WORD_SIZE = 32,
    parameter int PC_SIZE   = 32,
    parameter int REG_ADDR  = 5
);
    logic [PC_SIZE+WORD_SIZE-1:0] i_if_id_reg;
    logic                         i_wb_we;
    logic [REG_ADDR-1:0]          i_wb_addr;
    logic [WORD_SIZE-1:0]         i_wb_data;
    logic                         i_ex_mem_read;
    logic [REG_ADDR-1:0]          i_ex_rd;
    logic                         i_flush;

    logic                         o_stall;
    logic                         o_id_ex_valid;
    logic [PC_SIZE-1:0]           o_id_ex_pc;
    logic [WORD_SIZE-1:0]         o_id_ex_rs1_data;
    logic [WORD_SIZE-1:0]         o_id_ex_rs2_data;
    logic [WORD_SIZE-1:0]         o_id_ex_imm;
    logic [REG_ADDR-1:0]          o_id_ex_rs1;
    logic [REG_ADDR-1:0]          o_id_ex_rs2;
    logic [REG_ADDR-1:0]          o_id_ex_rd;
    logic [3:0]                   o_id_ex_funct;
    logic [7:0]                   o_id_ex_ctrl;

    modport master (
        output i_if_id_reg, i_wb_we, i_wb_addr, i_wb_data, i_ex_mem_read, i_ex_rd, i_flush,
        input  o_stall, o_id_ex_valid, o_id_ex_pc, o_id_ex_rs1_data, o_id_ex_rs2_data,
               o_id_ex_imm, o_id_ex_rs1, o_id_ex_rs2, o_id_ex_rd, o_id_ex_funct, o_id_ex_ctrl
    );

    modport slave (
        input  i_if_id_reg, i_wb_we, i_wb_addr, i_wb_data, i_ex_mem_read, i_ex_rd, i_flush,
        output o_stall, o_id_ex_valid, o_id_ex_pc, o_id_ex_rs1_data, o_id_ex_rs2_data,
               o_id_ex_imm, o_id_ex_rs1, o_id_ex_rs2, o_id_ex_rd, o_id_ex_funct, o_id_ex_ctrl
    );
endinterface

// File: rtl/inst_decode.sv
// RV32I decode stage: register file, immediates, control, load-use stall; IF/ID to ID/EX in 1 cycle.
// Backpressure: o_stall (combinational) holds IF and loads a bubble into ID/EX; flush also loads a bubble.
module inst_decode #(
    parameter int WORD_SIZE = 32,
    parameter int PC_SIZE   = 32,
    parameter int REG_ADDR  = 5
) (
    input  logic         i_clk,
    input  logic         i_rst,
    inst_decode_if.slave dec
);
    localparam int NREGS = 1 << REG_ADDR;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic pc_to_alu;
        logic jump;
        logic branch;
        logic mem_to_reg;
        logic mem_write;
        logic mem_read;
        logic alu_src;
        logic reg_write;
    } ctrl_t;

    typedef struct packed {
        logic                 valid;
        logic [PC_SIZE-1:0]   pc;
        logic [WORD_SIZE-1:0] rs1_data;
        logic [WORD_SIZE-1:0] rs2_data;
        logic [WORD_SIZE-1:0] imm;
        logic [REG_ADDR-1:0]  rs1;
        logic [REG_ADDR-1:0]  rs2;
        logic [REG_ADDR-1:0]  rd;
        logic [3:0]           funct;
        ctrl_t                ctrl;
    } id_ex_t;

    logic [WORD_SIZE-1:0] instr;
    logic [PC_SIZE-1:0]   pc;
    logic [6:0]           opcode;
    logic [REG_ADDR-1:0]  rs1;
    logic [REG_ADDR-1:0]  rs2;
    logic [REG_ADDR-1:0]  rd;

    assign instr  = dec.i_if_id_reg[WORD_SIZE-1:0];
    assign pc     = dec.i_if_id_reg[PC_SIZE+WORD_SIZE-1:WORD_SIZE];
    assign opcode = instr[6:0];
    assign rs2    = instr[24:20];
    assign rd     = instr[11:7];

    ctrl_t                ctrl;
    logic [WORD_SIZE-1:0] imm;
    logic                 legal;
    logic                 rs1_used;
    logic                 rs2_used;
    logic                 rs1_zero;

    always_comb begin
        ctrl     = '0;
        imm      = '0;
        legal    = 1'b1;
        rs1_used = 1'b1;
        rs2_used = 1'b0;
        rs1_zero = 1'b0;
        unique case (opcode)
            OP_R: begin
                ctrl     = ctrl_t'(8'h01);
                rs2_used = 1'b1;
            end
            OP_IMM: begin
                ctrl = ctrl_t'(8'h03);
                imm  = {{(WORD_SIZE-12){instr[31]}}, instr[31:20]};
            end
            OP_LOAD: begin
                ctrl = ctrl_t'(8'h17);
                imm  = {{(WORD_SIZE-12){instr[31]}}, instr[31:20]};
            end
            OP_STORE: begin
                ctrl     = ctrl_t'(8'h0A);
                rs2_used = 1'b1;
                imm      = {{(WORD_SIZE-12){instr[31]}}, instr[31:25], instr[11:7]};
            end
            OP_BRANCH: begin
                ctrl     = ctrl_t'(8'h20);
                rs2_used = 1'b1;
                imm      = {{(WORD_SIZE-13){instr[31]}}, instr[31], instr[7],
                            instr[30:25], instr[11:8], 1'b0};
            end
            OP_JAL: begin
                ctrl     = ctrl_t'(8'hC1);
                rs1_used = 1'b0;
                imm      = {{(WORD_SIZE-21){instr[31]}}, instr[31], instr[19:12],
                            instr[20], instr[30:21], 1'b0};
            end
            OP_JALR: begin
                ctrl = ctrl_t'(8'h43);
                imm  = {{(WORD_SIZE-12){instr[31]}}, instr[31:20]};
            end
            OP_LUI: begin
                ctrl     = ctrl_t'(8'h03);
                rs1_used = 1'b0;
                rs1_zero = 1'b1;
                imm      = {{(WORD_SIZE-31){instr[31]}}, instr[30:12], 12'b0};
            end
            OP_AUIPC: begin
                ctrl     = ctrl_t'(8'h83);
                rs1_used = 1'b0;
                imm      = {{(WORD_SIZE-31){instr[31]}}, instr[30:12], 12'b0};
            end
            default: begin
                legal    = 1'b0;
                rs1_used = 1'b0;
            end
        endcase
    end

    // LUI reads x0 so downstream forwarding never matches a stale rs1 field.
    assign rs1 = rs1_zero ? '0 : instr[19:15];

    logic [WORD_SIZE-1:0] regs [NREGS];
    logic                 wb_hit;

    assign wb_hit = dec.i_wb_we && (dec.i_wb_addr != '0);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_hit) begin
            regs[dec.i_wb_addr] <= dec.i_wb_data;
        end
    end

    logic [WORD_SIZE-1:0] rs1_data;
    logic [WORD_SIZE-1:0] rs2_data;

    always_comb begin
        rs1_data = '0;
        if (rs1 != '0) begin
            rs1_data = (wb_hit && dec.i_wb_addr == rs1) ? dec.i_wb_data : regs[rs1];
        end
    end

    always_comb begin
        rs2_data = '0;
        if (rs2 != '0) begin
            rs2_data = (wb_hit && dec.i_wb_addr == rs2) ? dec.i_wb_data : regs[rs2];
        end
    end

    logic stall;

    assign stall = i_rst && dec.i_ex_mem_read && (dec.i_ex_rd != '0) &&
                   ((rs1_used && dec.i_ex_rd == rs1) || (rs2_used && dec.i_ex_rd == rs2));
    assign dec.o_stall = stall;

    id_ex_t id_ex_nxt;
    id_ex_t id_ex_q;

    always_comb begin
        id_ex_nxt = '0;
        if (legal && !dec.i_flush && !stall) begin
            id_ex_nxt.valid    = 1'b1;
            id_ex_nxt.pc       = pc;
            id_ex_nxt.rs1_data = rs1_data;
            id_ex_nxt.rs2_data = rs2_data;
            id_ex_nxt.imm      = imm;
            id_ex_nxt.rs1      = rs1;
            id_ex_nxt.rs2      = rs2;
            id_ex_nxt.rd       = rd;
            id_ex_nxt.funct    = {instr[30], instr[14:12]};
            id_ex_nxt.ctrl     = ctrl;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            id_ex_q <= '0;
        end else begin
            id_ex_q <= id_ex_nxt;
        end
    end

    assign dec.o_id_ex_valid    = id_ex_q.valid;
    assign dec.o_id_ex_pc       = id_ex_q.pc;
    assign dec.o_id_ex_rs1_data = id_ex_q.rs1_data;
    assign dec.o_id_ex_rs2_data = id_ex_q.rs2_data;
    assign dec.o_id_ex_imm      = id_ex_q.imm;
    assign dec.o_id_ex_rs1      = id_ex_q.rs1;
    assign dec.o_id_ex_rs2      = id_ex_q.rs2;
    assign dec.o_id_ex_rd       = id_ex_q.rd;
    assign dec.o_id_ex_funct    = id_ex_q.funct;
    assign dec.o_id_ex_ctrl     = id_ex_q.ctrl;
endmodule
